// File: rtl/traffic_phase_ctrl.sv
// N-way traffic signal sequencer: round-robin GREEN -> YELLOW -> ALL-RED with its own
// countdown, flashing night/fault mode and emergency preemption.
module traffic_phase_ctrl #(
    parameter int unsigned N_DIR    = 4,
    parameter int unsigned GREEN_T  = 10,
    parameter int unsigned YELLOW_T = 3,
    parameter int unsigned ALLRED_T = 1,
    parameter int unsigned CNT_W    = 5,
    parameter int unsigned DIR_W    = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Tick,
    input  logic                 flash_mode,
    input  logic                 preempt_req,
    input  logic [DIR_W-1:0]     preempt_dir,
    output logic [3*N_DIR-1:0]   led_out,
    output logic [CNT_W-1:0]     count_out,
    output logic [DIR_W-1:0]     active_dir,
    output logic [1:0]           phase
);

    localparam int unsigned LED_W = 3 * N_DIR;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10,
        PH_FLASH  = 2'b11
    } phase_e;

    phase_e             phase_q, phase_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DIR_W-1:0]   dir_q, dir_d;
    logic [DIR_W-1:0]   tgt_q, tgt_d;
    logic               pend_q, pend_d;
    logic               flash_q, flash_d;
    logic [LED_W-1:0]   led_q, led_d;

    logic               preempt_ok;
    logic               hold_timing;
    logic [DIR_W-1:0]   rr_next;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            phase_q <= PH_ALLRED;
            count_q <= CNT_W'(ALLRED_T);
            dir_q   <= '0;
            tgt_q   <= '0;
            pend_q  <= 1'b0;
            flash_q <= 1'b0;
            led_q   <= {N_DIR{3'b100}};
        end else begin
            phase_q <= phase_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            tgt_q   <= tgt_d;
            pend_q  <= pend_d;
            flash_q <= flash_d;
            led_q   <= led_d;
        end
    end

    // Next-state: flash overrides preemption, preemption overrides normal timing
    always_comb begin
        phase_d     = phase_q;
        count_d     = count_q;
        dir_d       = dir_q;
        tgt_d       = tgt_q;
        pend_d      = pend_q;
        flash_d     = flash_q;
        led_d       = '0;
        hold_timing = 1'b0;
        preempt_ok  = preempt_req && (32'(preempt_dir) < N_DIR);
        rr_next     = (dir_q == DIR_W'(N_DIR - 1)) ? '0 : dir_q + DIR_W'(1);

        if (flash_mode) begin
            if (phase_q != PH_FLASH) begin
                phase_d = PH_FLASH;
                count_d = '0;
                flash_d = 1'b0;
                pend_d  = 1'b0;
            end else if (Tick) begin
                flash_d = ~flash_q;
            end
        end else if (phase_q == PH_FLASH) begin
            phase_d = PH_ALLRED;
            count_d = CNT_W'(ALLRED_T);
            dir_d   = '0;
        end else begin
            if (preempt_ok) begin
                unique case (phase_q)
                    PH_GREEN: begin
                        hold_timing = 1'b1;
                        if (dir_q != preempt_dir) begin
                            phase_d = PH_YELLOW;
                            count_d = CNT_W'(YELLOW_T);
                            tgt_d   = preempt_dir;
                            pend_d  = 1'b1;
                        end else begin
                            count_d = CNT_W'(GREEN_T);
                        end
                    end
                    PH_YELLOW: begin
                        tgt_d  = preempt_dir;
                        pend_d = 1'b1;
                    end
                    PH_ALLRED: dir_d = preempt_dir;
                    default: ;
                endcase
            end

            if (Tick && !hold_timing) begin
                if (count_q != CNT_W'(1)) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    unique case (phase_q)
                        PH_GREEN: begin
                            phase_d = PH_YELLOW;
                            count_d = CNT_W'(YELLOW_T);
                        end
                        PH_YELLOW: begin
                            phase_d = PH_ALLRED;
                            count_d = CNT_W'(ALLRED_T);
                            dir_d   = pend_d ? tgt_d : rr_next;
                            pend_d  = 1'b0;
                        end
                        PH_ALLRED: begin
                            phase_d = PH_GREEN;
                            count_d = CNT_W'(GREEN_T);
                        end
                        default: ;
                    endcase
                end
            end
        end

        // Direction 0 occupies the most significant LED triplet
        for (int k = 0; k < int'(N_DIR); k++) begin
            if (phase_d == PH_FLASH)
                led_d[3*(int'(N_DIR)-1-k) +: 3] = {1'b0, flash_d, 1'b0};
            else if (phase_d != PH_ALLRED && dir_d == DIR_W'(k))
                led_d[3*(int'(N_DIR)-1-k) +: 3] = (phase_d == PH_GREEN) ? 3'b001 : 3'b010;
            else
                led_d[3*(int'(N_DIR)-1-k) +: 3] = 3'b100;
        end
    end

    assign led_out    = led_q;
    assign count_out  = count_q;
    assign active_dir = dir_q;
    assign phase      = phase_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomised and directed bench for traffic_phase_ctrl against a behavioural phase model.
module tb_traffic_phase_ctrl;

    localparam int N   = 4;
    localparam int GT  = 5;
    localparam int YT  = 2;
    localparam int AT  = 1;
    localparam int CW  = 5;
    localparam int DW  = 2;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic            Tick = 1'b0;
    logic            flash_mode = 1'b0;
    logic            preempt_req = 1'b0;
    logic [DW-1:0]   preempt_dir = '0;
    logic [3*N-1:0]  led_out;
    logic [CW-1:0]   count_out;
    logic [DW-1:0]   active_dir;
    logic [1:0]      phase;

    int vectors = 0;
    int miscompares = 0;

    // Model state: phase 0=G 1=Y 2=AR 3=FLASH
    int m_ph, m_cnt, m_dir, m_fl, m_pend, m_tgt;

    traffic_phase_ctrl #(
        .N_DIR(N), .GREEN_T(GT), .YELLOW_T(YT), .ALLRED_T(AT), .CNT_W(CW)
    ) dut (
        .CLK(CLK), .RST(RST), .Tick(Tick), .flash_mode(flash_mode),
        .preempt_req(preempt_req), .preempt_dir(preempt_dir),
        .led_out(led_out), .count_out(count_out), .active_dir(active_dir), .phase(phase)
    );

    always #5 CLK = ~CLK;

    function automatic logic [3*N-1:0] exp_led();
        logic [3*N-1:0] v;
        logic [2:0] lamp;
        v = '0;
        for (int k = 0; k < N; k++) begin
            if (m_ph == 3)                     lamp = (m_fl != 0) ? 3'b010 : 3'b000;
            else if (m_ph != 2 && k == m_dir)  lamp = (m_ph == 0) ? 3'b001 : 3'b010;
            else                               lamp = 3'b100;
            v = v | ((3*N)'(lamp) << (3 * (N - 1 - k)));
        end
        return v;
    endfunction

    task automatic model_step(input bit t, input bit fm, input bit pr, input int pd, input bit rst);
        bit frozen;
        frozen = 0;
        if (rst) begin
            m_ph = 2; m_cnt = AT; m_dir = 0; m_fl = 0; m_pend = 0;
        end else if (fm) begin
            if (m_ph != 3) begin m_ph = 3; m_cnt = 0; m_fl = 0; m_pend = 0; end
            else if (t) m_fl = 1 - m_fl;
        end else if (m_ph == 3) begin
            m_ph = 2; m_cnt = AT; m_dir = 0;
        end else begin
            if (pr && pd < N) begin
                if (m_ph == 0 && m_dir != pd) begin
                    m_ph = 1; m_cnt = YT; m_pend = 1; m_tgt = pd; frozen = 1;
                end else if (m_ph == 0) begin
                    m_cnt = GT; frozen = 1;
                end else if (m_ph == 1) begin
                    m_pend = 1; m_tgt = pd;
                end else begin
                    m_dir = pd;
                end
            end
            if (t && !frozen) begin
                if (m_cnt > 1) m_cnt = m_cnt - 1;
                else if (m_ph == 0) begin m_ph = 1; m_cnt = YT; end
                else if (m_ph == 1) begin
                    m_ph = 2; m_cnt = AT;
                    m_dir = (m_pend != 0) ? m_tgt : (m_dir + 1) % N;
                    m_pend = 0;
                end else begin m_ph = 0; m_cnt = GT; end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive on falling edge, update model at rising edge, compare 1ns later
    task automatic cyc(input bit t, input bit fm, input bit pr, input int pd, input bit rst);
        @(negedge CLK);
        Tick = t; flash_mode = fm; preempt_req = pr; preempt_dir = DW'(pd); RST = rst;
        @(posedge CLK);
        model_step(t, fm, pr, pd, rst);
        #1;
        check("led_out", 32'(led_out), 32'(exp_led()));
        check("count_out", 32'(count_out), 32'(m_cnt));
        check("active_dir", 32'(active_dir), 32'(m_dir));
        check("phase", 32'(phase), 32'(m_ph));
    endtask

    task automatic run_to(input int ph, input int dir);
        bit hit;
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            cyc(1, 0, 0, 0, 0);
            hit = (m_ph == ph && m_dir == dir);
        end
        if (!hit) begin
            vectors++;
            miscompares++;
            $display("FAIL run_to: phase %0d dir %0d not reached within 200 ticks", ph, dir);
        end
    endtask

    initial begin
        bit fm_r, pr_r;
        int pd_r;
        m_ph = 2; m_cnt = AT; m_dir = 0; m_fl = 0; m_pend = 0; m_tgt = 0;

        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        check("rst_led", 32'(led_out), 32'(12'b100_100_100_100));
        check("rst_count", 32'(count_out), 32'd1);
        check("rst_dir", 32'(active_dir), 32'd0);
        check("rst_phase", 32'(phase), 32'd2);
        cyc(0, 0, 0, 0, 0);

        // Basic sequence
        cyc(1, 0, 0, 0, 0);
        check("t1_green0", 32'(led_out), 32'(12'b001_100_100_100));
        check("t1_cnt5", 32'(count_out), 32'd5);
        repeat (5) cyc(1, 0, 0, 0, 0);
        check("t1_yel0", 32'(led_out), 32'(12'b010_100_100_100));
        check("t1_cnt2", 32'(count_out), 32'd2);
        repeat (2) cyc(1, 0, 0, 0, 0);
        check("t1_allred", 32'(led_out), 32'(12'b100_100_100_100));
        check("t1_next1", 32'(active_dir), 32'd1);
        check("t1_cnt1", 32'(count_out), 32'd1);
        cyc(1, 0, 0, 0, 0);
        check("t1_green1", 32'(led_out), 32'(12'b100_001_100_100));

        // Wrap 3 -> 0 and hold without Tick
        run_to(1, 3);
        repeat (2) cyc(1, 0, 0, 0, 0);
        check("t2_wrap_dir", 32'(active_dir), 32'd0);
        check("t2_wrap_phase", 32'(phase), 32'd2);
        cyc(1, 0, 0, 0, 0);
        repeat (50) cyc(0, 0, 0, 0, 0);
        check("t2_hold_led", 32'(led_out), 32'(12'b001_100_100_100));
        check("t2_hold_cnt", 32'(count_out), 32'd5);

        // Flash mode
        run_to(0, 1);
        repeat (2) cyc(1, 0, 0, 0, 0);
        check("t3_cnt3", 32'(count_out), 32'd3);
        cyc(0, 1, 0, 0, 0);
        check("t3_flash_ph", 32'(phase), 32'd3);
        check("t3_flash_led0", 32'(led_out), 32'd0);
        check("t3_flash_cnt", 32'(count_out), 32'd0);
        cyc(1, 1, 0, 0, 0);
        check("t3_flash_on", 32'(led_out), 32'(12'b010_010_010_010));
        cyc(1, 1, 0, 0, 0);
        check("t3_flash_off", 32'(led_out), 32'd0);
        cyc(0, 0, 0, 0, 0);
        check("t3_exit_ph", 32'(phase), 32'd2);
        check("t3_exit_dir", 32'(active_dir), 32'd0);
        check("t3_exit_cnt", 32'(count_out), 32'd1);

        // Preemption during GREEN
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("t4_cnt4", 32'(count_out), 32'd4);
        cyc(0, 0, 1, 2, 0);
        check("t4_yel_ph", 32'(phase), 32'd1);
        check("t4_yel_cnt", 32'(count_out), 32'd2);
        repeat (2) cyc(1, 0, 1, 2, 0);
        check("t4_ar_dir", 32'(active_dir), 32'd2);
        cyc(1, 0, 1, 2, 0);
        check("t4_green2", 32'(led_out), 32'(12'b100_100_001_100));
        repeat (3) cyc(1, 0, 1, 2, 0);
        check("t4_hold5", 32'(count_out), 32'd5);

        // Reset and flash entry coinciding with Tick
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        check("t5_rst_led", 32'(led_out), 32'(12'b100_100_100_100));
        check("t5_rst_cnt", 32'(count_out), 32'd1);
        check("t5_rst_dir", 32'(active_dir), 32'd0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        check("t5_flash_led", 32'(led_out), 32'd0);
        check("t5_flash_ph", 32'(phase), 32'd3);
        cyc(0, 0, 0, 0, 0);

        // Preemption latched during YELLOW
        run_to(1, 3);
        cyc(0, 0, 1, 1, 0);
        check("t6_yel_cnt", 32'(count_out), 32'd2);
        repeat (2) cyc(1, 0, 0, 0, 0);
        check("t6_ar_dir", 32'(active_dir), 32'd1);
        check("t6_ar_ph", 32'(phase), 32'd2);
        cyc(1, 0, 0, 0, 0);
        check("t6_green1", 32'(led_out), 32'(12'b100_001_100_100));

        // Random traffic
        fm_r = 0; pr_r = 0; pd_r = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0) fm_r = !fm_r;
            if ($urandom_range(0, 19) == 0) begin
                pr_r = !pr_r;
                pd_r = int'($urandom_range(0, N - 1));
            end
            cyc(bit'($urandom_range(0, 1)), fm_r, pr_r, pd_r, $urandom_range(0, 499) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
